lsu_arbiter: RTL and testbench
==============================

// Module: lsu_arbiter
// PURPOSE
//  Two-master arbiter in front of the single lsu port (data memory + LEDR/LEDG/SEG/LCD/SW/BTN map).
//  Master 0 is the core datapath; master 1 is the debug/program loader.
//  One access per clock is granted, muxed onto the lsu port, and load data is returned registered.
//  Aging prevents m1 starvation. A lock mode gives m1 back-to-back bursts, e.g. loading memory or refreshing LCD.
// PARAMETERS
//  MAX_WAIT  4   cycles m1 may be denied before it is force-granted over m0 (>=1)
//  LOCK_MAX  16  max consecutive m1 grants in lock mode before forced release (>=2)
// PORTS
//  i_clk          in   1   clock, all state on rising edge
//  i_reset        in   1   asynchronous, active-low reset
//  i_m0_req       in   1   m0 access request (held until granted)
//  i_m0_wren      in   1   m0 store (1) / load (0)
//  i_m0_addr      in   32  m0 byte address
//  i_m0_stData    in   32  m0 store data, right-aligned
//  i_m0_mask      in   4   m0 byte mask (0001 B, 0011 H, 1111 W)
//  o_m0_gnt       out  1   m0 granted this cycle (combinational)
//  o_m0_rvalid    out  1   m0 load data valid (cycle after load grant)
//  o_m0_rdata     out  32  m0 load data, registered
//  i_m1_req / i_m1_wren / i_m1_addr / i_m1_stData / i_m1_mask  in  1/1/32/32/4  as m0
//  i_m1_lock      in   1   m1 requests to keep the port after this grant
//  o_m1_gnt / o_m1_rvalid / o_m1_rdata  out  1/1/32  as m0
//  o_lsu_addr     out  32  to lsu i_addr
//  o_lsu_stData   out  32  to lsu i_stData
//  o_lsu_wren     out  1   to lsu i_wren; 0 whenever no grant
//  o_lsu_mask     out  4   to lsu i_mask
//  i_lsu_ldData   in   32  from lsu o_ldData (combinational read)
// BEHAVIOUR
//  Reset: state=IDLE, age=0, lock_cnt=0, rvalid*=0, rdata*=0.
//   Reset mid-lock drops lock; a load granted in the reset cycle gives no rvalid.
//  Grant per cycle, exclusive; gnt is asserted only together with the matching req:
//   LOCK1 state -> m1 only; m0 waits.
//   IDLE: m1 wins if age==MAX_WAIT, or if m0 is not requesting. Otherwise m0 wins.
//  Mux: the granted master drives o_lsu_*. No grant -> wren=0, addr=0, stData=0, mask=0.
//  Store: committed by lsu at the grant edge. No rvalid for stores.
//  Load: at the grant edge, i_lsu_ldData is captured into that master's rdata.
//   rvalid pulses 1 cycle; rdata holds until that master's next load.
//  Aging (age, width clog2(MAX_WAIT+1)):
//   m1 req && !m1 gnt -> +1, saturating at MAX_WAIT.
//   m1 gnt or !m1 req -> 0.
//  FSM:
//   IDLE -> LOCK1 when m1 granted with i_m1_lock=1; lock_cnt=1.
//   LOCK1 with m1 granted and lock=1: lock_cnt+1; if lock_cnt==LOCK_MAX-1 -> IDLE, lock_cnt=0.
//   LOCK1 with m1 granted and lock=0 -> IDLE (last grant).
//   LOCK1 with !m1 req -> IDLE, no grant.
//  Forced release: after a cap release, m0 wins the next cycle if requesting.
//   age may be at MAX_WAIT; force-grant applies only in IDLE with age==MAX_WAIT, and not in the
//   first cycle after a cap release.
//  Simultaneous m0/m1 at age<MAX_WAIT -> m0. Both masters idle -> no grant, no rvalid.
// STRUCTURE
//  lsu_arb_pkg: typedef enum logic {IDLE, LOCK1} arb_state_e; MASK_B/MASK_H/MASK_W;
//   typedef struct {req, wren, addr, stData, mask} lsu_req_t.
//  Sub-module lsu_arb_ager: saturating wait counter with clear and sat flag, parameter MAX_WAIT.
//  Top holds the FSM, lock_cnt, grant logic, output mux and rdata/rvalid registers.
// TESTING
//  1 Reset: i_reset=0 with both reqs high -> all gnt/rvalid/rdata 0, o_lsu_wren=0.
//  2 m0 only: store W 0x1234_5678 @0x0, then load @0x0 -> gnt same cycle; next cycle m0_rvalid=1,
//    m0_rdata=0x1234_5678, m1_rvalid=0.
//  3 Contention, MAX_WAIT=4, both req every cycle -> m0 granted 4 cycles, m1 on the 5th, then m0.
//    age back to 0 after the m1 grant.
//  4 m1 lock burst of 3 byte stores 0x21/0x31/0x41 to 0x401..0x403 with lock=1,1,0 while m0 reqs
//    -> 3 consecutive m1 gnts, then m0 gnt; word load @0x400 reads 0x4131_21xx.
//  5 Lock cap, LOCK_MAX=16, m1 lock held -> exactly 16 m1 gnts, then 1 m0 gnt, then m1 resumes.
//  6 Async reset at 3rd beat of a locked burst -> state IDLE, no rvalid;
//    after release m0 granted first when both request.

Source files
------------

// File: rtl/lsu_arb_pkg.sv
// Shared types for the two-master LSU arbiter: FSM states, byte masks and the
// bundled request a master presents to the arbiter.
package lsu_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        LOCK1 = 1'b1
    } arb_state_e;

    localparam logic [3:0] MASK_B = 4'b0001;
    localparam logic [3:0] MASK_H = 4'b0011;
    localparam logic [3:0] MASK_W = 4'b1111;

    typedef struct packed {
        logic        req;
        logic        wren;
        logic [31:0] addr;
        logic [31:0] stData;
        logic [3:0]  mask;
    } lsu_req_t;

endpackage

// File: rtl/lsu_arb_ager.sv
// Saturating wait counter for master 1: counts denied cycles, clears on grant
// or when the request goes away, and flags when it has reached MAX_WAIT.
module lsu_arb_ager #(
    parameter int MAX_WAIT = 4,
    parameter int CW       = $clog2(MAX_WAIT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CW-1:0] count;

    assign sat = (count == CW'(MAX_WAIT));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !sat) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/lsu_arbiter.sv
// Two-master arbiter in front of the single LSU port: aging protects master 1
// from starvation and a lock mode grants it capped back-to-back bursts.
module lsu_arbiter
    import lsu_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4,
    parameter int LOCK_MAX = 16
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_m0_req,
    input  logic        i_m0_wren,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_stData,
    input  logic [3:0]  i_m0_mask,
    output logic        o_m0_gnt,
    output logic        o_m0_rvalid,
    output logic [31:0] o_m0_rdata,
    input  logic        i_m1_req,
    input  logic        i_m1_wren,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_stData,
    input  logic [3:0]  i_m1_mask,
    input  logic        i_m1_lock,
    output logic        o_m1_gnt,
    output logic        o_m1_rvalid,
    output logic [31:0] o_m1_rdata,
    output logic [31:0] o_lsu_addr,
    output logic [31:0] o_lsu_stData,
    output logic        o_lsu_wren,
    output logic [3:0]  o_lsu_mask,
    input  logic [31:0] i_lsu_ldData
);

    localparam int LW = $clog2(LOCK_MAX);

    lsu_req_t   m0, m1, sel;
    arb_state_e state, state_next;
    logic [LW-1:0] lock_cnt, lock_cnt_next;
    logic cap_rel, cap_rel_next;
    logic age_sat;
    logic m0_gnt, m1_gnt;

    assign m0 = '{req: i_m0_req, wren: i_m0_wren, addr: i_m0_addr,
                  stData: i_m0_stData, mask: i_m0_mask};
    assign m1 = '{req: i_m1_req, wren: i_m1_wren, addr: i_m1_addr,
                  stData: i_m1_stData, mask: i_m1_mask};

    lsu_arb_ager #(.MAX_WAIT(MAX_WAIT)) u_ager (
        .clk   (i_clk),
        .rst_n (i_reset),
        .inc   (m1.req),
        .clr   (m1_gnt || !m1.req),
        .sat   (age_sat)
    );

    // No grant while reset is held, so nothing reaches the LSU in that cycle.
    // NOTE: every always_comb output gets a default first, which rules out latches.
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (i_reset) begin
            if (state == LOCK1) begin
                m1_gnt = m1.req;
            end else if (m1.req && (!m0.req || (age_sat && !cap_rel))) begin
                m1_gnt = 1'b1;
            end else begin
                m0_gnt = m0.req;
            end
        end
    end

    always_comb begin
        state_next    = state;
        lock_cnt_next = lock_cnt;
        cap_rel_next  = 1'b0;
        case (state)
            IDLE: begin
                if (m1_gnt && i_m1_lock) begin
                    state_next    = LOCK1;
                    lock_cnt_next = LW'(1);
                end
            end
            LOCK1: begin
                if (!m1.req || !i_m1_lock) begin
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                end else if (lock_cnt == LW'(LOCK_MAX - 1)) begin
                    // Cap reached: hand the next cycle to m0 even if m1 has aged.
                    state_next    = IDLE;
                    lock_cnt_next = '0;
                    cap_rel_next  = 1'b1;
                end else begin
                    lock_cnt_next = lock_cnt + LW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sel = '0;
        if (m0_gnt) begin
            sel = m0;
        end else if (m1_gnt) begin
            sel = m1;
        end
    end

    assign o_m0_gnt     = m0_gnt;
    assign o_m1_gnt     = m1_gnt;
    assign o_lsu_addr   = sel.addr;
    assign o_lsu_stData = sel.stData;
    assign o_lsu_wren   = sel.req & sel.wren;
    assign o_lsu_mask   = sel.mask;

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state       <= IDLE;
            lock_cnt    <= '0;
            cap_rel     <= 1'b0;
            o_m0_rvalid <= 1'b0;
            o_m1_rvalid <= 1'b0;
            o_m0_rdata  <= '0;
            o_m1_rdata  <= '0;
        end else begin
            state       <= state_next;
            lock_cnt    <= lock_cnt_next;
            cap_rel     <= cap_rel_next;
            o_m0_rvalid <= m0_gnt && !m0.wren;
            o_m1_rvalid <= m1_gnt && !m1.wren;
            if (m0_gnt && !m0.wren) begin
                o_m0_rdata <= i_lsu_ldData;
            end
            if (m1_gnt && !m1.wren) begin
                o_m1_rdata <= i_lsu_ldData;
            end
        end
    end

endmodule

// File: tb/tb_lsu_arbiter.sv
// Bench for lsu_arbiter: directed scenarios then randomized held-until-granted
// traffic, all compared cycle by cycle against a behavioural arbitration model.
module tb_lsu_arbiter;
    import lsu_arb_pkg::*;

    localparam int MAX_WAIT = 4;
    localparam int LOCK_MAX = 16;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    lsu_req_t    m0    = '0;
    lsu_req_t    m1    = '0;
    logic        m1_lock = 1'b0;
    logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
    logic [31:0] m0_rdata, m1_rdata, lsu_addr, lsu_st, ld_data;
    logic        lsu_wren;
    logic [3:0]  lsu_mask;

    bit [7:0] mem     [0:4095];
    bit [7:0] ref_mem [0:4095];

    bit          in_burst, just_capped;
    int          burst_len, waited;
    bit          exp_g0, exp_g1, exp_rv0, exp_rv1;
    logic [31:0] exp_rd0, exp_rd1;
    bit          obs_g0, obs_g1;
    int          n_checks = 0;
    int          n_fail   = 0;

    lsu_arbiter #(.MAX_WAIT(MAX_WAIT), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk        (clk),
        .i_reset      (rst_n),
        .i_m0_req     (m0.req),
        .i_m0_wren    (m0.wren),
        .i_m0_addr    (m0.addr),
        .i_m0_stData  (m0.stData),
        .i_m0_mask    (m0.mask),
        .o_m0_gnt     (m0_gnt),
        .o_m0_rvalid  (m0_rvalid),
        .o_m0_rdata   (m0_rdata),
        .i_m1_req     (m1.req),
        .i_m1_wren    (m1.wren),
        .i_m1_addr    (m1.addr),
        .i_m1_stData  (m1.stData),
        .i_m1_mask    (m1.mask),
        .i_m1_lock    (m1_lock),
        .o_m1_gnt     (m1_gnt),
        .o_m1_rvalid  (m1_rvalid),
        .o_m1_rdata   (m1_rdata),
        .o_lsu_addr   (lsu_addr),
        .o_lsu_stData (lsu_st),
        .o_lsu_wren   (lsu_wren),
        .o_lsu_mask   (lsu_mask),
        .i_lsu_ldData (ld_data)
    );

    always #5 clk = ~clk;

    // LSU stand-in: combinational word read, byte-masked store at the edge.
    always_comb ld_data = {mem[lsu_addr[11:0] + 12'd3], mem[lsu_addr[11:0] + 12'd2],
                           mem[lsu_addr[11:0] + 12'd1], mem[lsu_addr[11:0]]};

    always @(posedge clk) begin
        if (lsu_wren) begin
            for (int i = 0; i < 4; i++) begin
                if (lsu_mask[i]) mem[lsu_addr[11:0] + 12'(i)] <= lsu_st[8*i +: 8];
            end
        end
    end

    function automatic logic [31:0] ref_word(input logic [31:0] a);
        return {ref_mem[a[11:0] + 12'd3], ref_mem[a[11:0] + 12'd2],
                ref_mem[a[11:0] + 12'd1], ref_mem[a[11:0]]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        in_burst    = 1'b0;
        just_capped = 1'b0;
        burst_len   = 0;
        waited      = 0;
        exp_rv0     = 1'b0;
        exp_rv1     = 1'b0;
        exp_rd0     = '0;
        exp_rd1     = '0;
    endtask

    task automatic predict();
        exp_g0 = 1'b0;
        exp_g1 = 1'b0;
        if (rst_n) begin
            if (in_burst) exp_g1 = m1.req;
            else if (m1.req && (!m0.req || (waited >= MAX_WAIT && !just_capped))) exp_g1 = 1'b1;
            else exp_g0 = m0.req;
        end
    endtask

    task automatic commit();
        lsu_req_t g;
        exp_rv0 = exp_g0 && !m0.wren;
        exp_rv1 = exp_g1 && !m1.wren;
        if (exp_rv0) exp_rd0 = ref_word(m0.addr);
        if (exp_rv1) exp_rd1 = ref_word(m1.addr);
        g = exp_g0 ? m0 : m1;
        if ((exp_g0 || exp_g1) && g.wren) begin
            for (int i = 0; i < 4; i++) begin
                if (g.mask[i]) ref_mem[g.addr[11:0] + 12'(i)] = g.stData[8*i +: 8];
            end
        end
        waited      = (m1.req && !exp_g1) ? ((waited < MAX_WAIT) ? waited + 1 : MAX_WAIT) : 0;
        just_capped = 1'b0;
        if (in_burst && !m1.req) begin
            in_burst  = 1'b0;
            burst_len = 0;
        end else if (exp_g1) begin
            if (!m1_lock) begin
                in_burst  = 1'b0;
                burst_len = 0;
            end else begin
                burst_len++;
                in_burst = 1'b1;
                if (burst_len == LOCK_MAX) begin
                    in_burst    = 1'b0;
                    burst_len   = 0;
                    just_capped = 1'b1;
                end
            end
        end
    endtask

    // Called just after an active edge with inputs already driven.
    task automatic cycle();
        lsu_req_t g;
        predict();
        #2;
        obs_g0 = m0_gnt;
        obs_g1 = m1_gnt;
        g = exp_g0 ? m0 : (exp_g1 ? m1 : '0);
        chk("m0_gnt", 32'(m0_gnt), 32'(exp_g0));
        chk("m1_gnt", 32'(m1_gnt), 32'(exp_g1));
        chk("lsu_wren", 32'(lsu_wren), 32'(g.req && g.wren));
        chk("lsu_addr", lsu_addr, g.addr);
        chk("lsu_stData", lsu_st, g.stData);
        chk("lsu_mask", 32'(lsu_mask), 32'(g.mask));
        @(posedge clk);
        commit();
        #1;
        chk("m0_rvalid", 32'(m0_rvalid), 32'(exp_rv0));
        chk("m1_rvalid", 32'(m1_rvalid), 32'(exp_rv1));
        chk("m0_rdata", m0_rdata, exp_rd0);
        chk("m1_rdata", m1_rdata, exp_rd1);
    endtask

    function automatic lsu_req_t rand_req(input int pct);
        lsu_req_t r;
        int k;
        r = '0;
        if (int'($urandom_range(99)) < pct) begin
            r.req    = 1'b1;
            r.wren   = 1'($urandom_range(1));
            r.stData = $urandom();
            r.addr   = {20'h0, 10'($urandom_range(1023)), 2'b00};
            r.mask   = MASK_W;
            k = int'($urandom_range(2));
            if (r.wren && k == 0) begin
                r.mask      = MASK_B;
                r.addr[1:0] = 2'($urandom_range(3));
            end else if (r.wren && k == 1) begin
                r.mask      = MASK_H;
                r.addr[1:0] = {1'($urandom_range(1)), 1'b0};
            end
        end
        return r;
    endfunction

    initial begin
        logic [31:0] g1_seq;
        int n1;

        model_reset();
        // Reset with both masters requesting
        m0 = '{req: 1'b1, wren: 1'b0, addr: 32'h0, stData: 32'h0, mask: MASK_W};
        m1 = '{req: 1'b1, wren: 1'b0, addr: 32'h4, stData: 32'h0, mask: MASK_W};
        #1 rst_n = 1'b0;
        #1;
        chk("rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("rst_lsu_wren", 32'(lsu_wren), 32'd0);
        chk("rst_m0_rdata", m0_rdata, 32'd0);
        chk("rst_m1_rdata", m1_rdata, 32'd0);
        @(posedge clk);
        #1;
        chk("rst_m0_rvalid", 32'(m0_rvalid), 32'd0);
        chk("rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        rst_n = 1'b1;

        // m0 alone: word store then load back
        m1 = '0;
        m0 = '{req: 1'b1, wren: 1'b1, addr: 32'h0, stData: 32'h1234_5678, mask: MASK_W};
        cycle();
        chk("t2_store_gnt", 32'(obs_g0), 32'd1);
        m0 = '{req: 1'b1, wren: 1'b0, addr: 32'h0, stData: 32'h0, mask: MASK_W};
        cycle();
        chk("t2_load_rvalid", 32'(m0_rvalid), 32'd1);
        chk("t2_load_rdata", m0_rdata, 32'h1234_5678);
        m0 = '0;
        cycle();

        // Constant contention: m1 every fifth cycle
        m0 = '{req: 1'b1, wren: 1'b0, addr: 32'h0, stData: 32'h0, mask: MASK_W};
        m1 = '{req: 1'b1, wren: 1'b0, addr: 32'h4, stData: 32'h0, mask: MASK_W};
        g1_seq = '0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            g1_seq[i] = obs_g1;
        end
        chk("t3_m1_pattern", g1_seq, 32'h0000_0210);

        // Locked byte-store burst, m0 joins on the second beat
        m0 = '0;
        m1 = '{req: 1'b1, wren: 1'b1, addr: 32'h401, stData: 32'h21, mask: MASK_B};
        m1_lock = 1'b1;
        n1 = 0;
        cycle();
        n1 += int'(obs_g1);
        m0 = '{req: 1'b1, wren: 1'b1, addr: 32'h800, stData: 32'hdead_beef, mask: MASK_W};
        m1 = '{req: 1'b1, wren: 1'b1, addr: 32'h402, stData: 32'h31, mask: MASK_B};
        cycle();
        n1 += int'(obs_g1);
        m1 = '{req: 1'b1, wren: 1'b1, addr: 32'h403, stData: 32'h41, mask: MASK_B};
        m1_lock = 1'b0;
        cycle();
        n1 += int'(obs_g1);
        chk("t4_burst_gnts", 32'(n1), 32'd3);
        m1 = '0;
        cycle();
        chk("t4_m0_after", 32'(obs_g0), 32'd1);
        m0 = '{req: 1'b1, wren: 1'b0, addr: 32'h400, stData: 32'h0, mask: MASK_W};
        cycle();
        chk("t4_word_load", 32'(m0_rdata[31:8]), 32'h0041_3121);
        m0 = '0;
        cycle();

        // Lock cap: m1 keeps lock, m0 waits from the second beat
        m1 = '{req: 1'b1, wren: 1'b1, addr: 32'h900, stData: 32'h5a, mask: MASK_B};
        m1_lock = 1'b1;
        cycle();
        n1 = int'(obs_g1);
        m0 = '{req: 1'b1, wren: 1'b1, addr: 32'h804, stData: 32'hcafe_f00d, mask: MASK_W};
        for (int i = 1; i < 40 && !obs_g0; i++) begin
            m1.addr = 32'h900 + 32'(i);
            cycle();
            n1 += int'(obs_g1);
        end
        chk("t5_cap_len", 32'(n1), 32'd16);
        chk("t5_m0_after_cap", 32'(obs_g0), 32'd1);
        m0 = '0;
        cycle();
        chk("t5_m1_resumes", 32'(obs_g1), 32'd1);
        m1_lock = 1'b0;
        cycle();
        m1 = '0;
        cycle();

        // Reset on the third beat of a locked load burst
        m1 = '{req: 1'b1, wren: 1'b0, addr: 32'h400, stData: 32'h0, mask: MASK_W};
        m1_lock = 1'b1;
        cycle();
        m0 = '{req: 1'b1, wren: 1'b1, addr: 32'h808, stData: 32'h0bad_f00d, mask: MASK_W};
        cycle();
        rst_n = 1'b0;
        #2;
        chk("t6_rst_m1_gnt", 32'(m1_gnt), 32'd0);
        chk("t6_rst_m0_gnt", 32'(m0_gnt), 32'd0);
        chk("t6_rst_m1_rvalid", 32'(m1_rvalid), 32'd0);
        chk("t6_rst_lsu_wren", 32'(lsu_wren), 32'd0);
        @(posedge clk);
        #1;
        model_reset();
        chk("t6_m1_rvalid_after", 32'(m1_rvalid), 32'd0);
        rst_n = 1'b1;
        m1_lock = 1'b0;
        m1 = '{req: 1'b1, wren: 1'b0, addr: 32'h404, stData: 32'h0, mask: MASK_W};
        cycle();
        chk("t6_m0_first", 32'(obs_g0), 32'd1);
        m0 = '0;
        cycle();
        m1 = '0;
        cycle();

        // Random traffic; each master holds its request until granted
        for (int c = 0; c < 600; c++) begin
            if (!m0.req || exp_g0) m0 = rand_req(50);
            if (!m1.req || exp_g1) begin
                m1 = rand_req(85);
                m1_lock = ($urandom_range(9) < 8);
            end
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
